// File: rtl/aesl_deadlock_param_monitor.sv
// -----------------------------------------------------------------------------
// aesl_deadlock_param_monitor
//
// Parametrised deadlock monitor for one dataflow region of the co-simulation
// harness. Each of NUM_CH channels pairs an "axis blocked" flag with an
// "owning instance idle" flag. Channels flagged in PAR_MASK form the parallel
// region (deadlocked when at least one is blocked and every one is blocked or
// idle). The remaining channels form the sequential region (deadlocked as soon
// as any one is blocked). A child monitor's block output is ORed in. The
// candidate must persist THRESH consecutive cycles before block asserts.
//
// Ports
//   clock            in   rising-edge clock
//   reset            in   asynchronous reset, active low
//   enable           in   0 forces and holds the monitor in IDLE
//   clear            in   synchronous clear of all state and outputs
//   axis_block_sigs  in   [NUM_CH] per-channel stream blocked
//   inst_idle_sigs   in   [NUM_CH] per-channel owning instance idle
//   inst_block_sigs  in   child monitor block, ORed into the candidate
//   block            out  deadlock reported
//   block_ch         out  lowest blocked channel, captured on entry to BLOCKED
//   stall_cycles     out  [CNT_W] current candidate run length, saturating
//
// Build option
//   AESL_DEADLOCK_STICKY_EN  defined: BLOCKED is left only via clear, enable=0
//                            or reset; cand=0 freezes the run counter.
//                            undefined: cand=0 in BLOCKED returns to IDLE.
// -----------------------------------------------------------------------------
module aesl_deadlock_param_monitor #(
    parameter int                NUM_CH   = 4,
    parameter logic [NUM_CH-1:0] PAR_MASK = 4'b0111,
    parameter int                THRESH   = 16,
    parameter int                CNT_W    = 16,
    localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [NUM_CH-1:0] axis_block_sigs,
    input  logic [NUM_CH-1:0] inst_idle_sigs,
    input  logic              inst_block_sigs,
    output logic              block,
    output logic [CH_W-1:0]   block_ch,
    output logic [CNT_W-1:0]  stall_cycles
);

    // The run counter is at least 16 bits so it can always reach THRESH,
    // even when the reported stall_cycles is narrower.
    localparam int                RUN_W     = (CNT_W > 16) ? CNT_W : 16;
    localparam logic [RUN_W-1:0]  THR       = RUN_W'(THRESH);
    localparam logic [RUN_W-1:0]  STALL_MAX = RUN_W'({CNT_W{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_BLOCKED = 2'd2
    } state_t;

    state_t             r_state;
    logic [RUN_W-1:0]   r_cnt;
    logic               r_block;
    logic [CH_W-1:0]    r_block_ch;
    logic [CNT_W-1:0]   r_stall;

    logic               w_par_dl;
    logic               w_single_dl;
    logic               w_cand;
    logic [CH_W-1:0]    w_enc;
    logic [CH_W-1:0]    w_hit_ch;
    logic [RUN_W-1:0]   w_cnt_inc;

    function automatic logic [CNT_W-1:0] sat_stall(input logic [RUN_W-1:0] c);
        return (c > STALL_MAX) ? {CNT_W{1'b1}} : c[CNT_W-1:0];
    endfunction

    always_comb begin
        // Non-parallel channels are forced to "ok" so they do not veto par_dl.
        w_par_dl    = (|(axis_block_sigs & PAR_MASK)) &&
                      (&(axis_block_sigs | inst_idle_sigs | ~PAR_MASK));
        w_single_dl = |(axis_block_sigs & ~PAR_MASK);
        w_cand      = w_par_dl | w_single_dl | inst_block_sigs;

        // Scan from the top so the lowest set index is the last one written.
        w_enc = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (axis_block_sigs[i]) w_enc = CH_W'(i);
        end
        // A deadlock raised only by the child monitor reports channel 0.
        w_hit_ch = (w_par_dl | w_single_dl) ? w_enc : '0;

        w_cnt_inc = (r_cnt == {RUN_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_block    <= 1'b0;
            r_block_ch <= '0;
            r_stall    <= '0;
        end else if (clear) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_block    <= 1'b0;
            r_block_ch <= '0;
            r_stall    <= '0;
        end else if (!enable) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_block    <= 1'b0;
            r_stall    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cand) begin
                        r_cnt   <= RUN_W'(1);
                        r_stall <= sat_stall(RUN_W'(1));
                        if (THRESH == 1) begin
                            r_state    <= S_BLOCKED;
                            r_block    <= 1'b1;
                            r_block_ch <= w_hit_ch;
                        end else begin
                            r_state <= S_ARMED;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_stall <= '0;
                        r_block <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (w_cand) begin
                        r_cnt   <= w_cnt_inc;
                        r_stall <= sat_stall(w_cnt_inc);
                        if (w_cnt_inc >= THR) begin
                            r_state    <= S_BLOCKED;
                            r_block    <= 1'b1;
                            r_block_ch <= w_hit_ch;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_stall <= '0;
                    end
                end
                S_BLOCKED: begin
                    if (w_cand) begin
                        r_cnt   <= w_cnt_inc;
                        r_stall <= sat_stall(w_cnt_inc);
                    end else begin
`ifdef AESL_DEADLOCK_STICKY_EN
                        // Sticky: hold block and freeze the run length.
                        r_cnt   <= r_cnt;
`else
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_stall <= '0;
                        r_block <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_stall <= '0;
                    r_block <= 1'b0;
                end
            endcase
        end
    end

    assign block        = r_block;
    assign block_ch     = r_block_ch;
    assign stall_cycles = r_stall;

endmodule
